// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch constants and the queue entry layout.
package riscv_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and core-side instruction handshake.
interface fetch_queue_if #(parameter int DEPTH = 4);
    import riscv_fetch_pkg::*;
    logic imem_req_valid;
    logic imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic instr_valid;
    logic instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic [$clog2(DEPTH+1)-1:0] queue_count;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, queue_count,
        input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, queue_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; depth need not be a power of two.
module fetch_fifo #(
    parameter int W = 32,
    parameter int D = 4,
    localparam int AW = D > 1 ? $clog2(D) : 1,
    localparam int CW = $clog2(D+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [D];
    logic [AW-1:0] rd, wr;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(D-1) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) if (push) mem[wr] <= din;
    assign dout = mem[rd];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction fetch with in-order queue and redirect flush.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic clk,
    input logic rst,
    fetch_queue_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int SW = $clog2(DEPTH+MAX_OUTSTANDING+1);
    logic [XLEN-1:0] fetch_pc, tag_pc, rsp_pc;
    logic [OW-1:0] outstanding, drop_count, tag_count;
    fetch_entry_t head;
    logic redir, fire, rsp_take, tag_push, tag_pop, pop;
    assign redir = bus.redirect_valid;
    // Credits count stale in-flight requests too, so every response has a reserved slot.
    assign bus.imem_req_valid = !rst && !redir
        && (SW'(bus.queue_count) + SW'(outstanding) < SW'(DEPTH))
        && (outstanding < OW'(MAX_OUTSTANDING));
    assign bus.imem_req_addr = fetch_pc;
    assign fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_take = bus.imem_rsp_valid && !redir && drop_count == '0;
    // An empty tag FIFO with a live response means the memory answered in the request cycle.
    assign rsp_pc = tag_count != '0 ? tag_pc : fetch_pc;
    assign tag_push = fire && !(rsp_take && tag_count == '0);
    assign tag_pop = rsp_take && tag_count != '0;
    assign pop = bus.instr_valid && bus.instr_ready && !redir;
    assign bus.instr_valid = bus.queue_count != '0;
    assign bus.instr_data = bus.instr_valid ? head.data : INSTR_NOP;
    assign bus.instr_pc = bus.instr_valid ? head.pc : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            outstanding <= '0;
            drop_count <= '0;
        end else if (redir) begin
            fetch_pc <= bus.redirect_pc & ~XLEN'(3);
            outstanding <= outstanding - OW'(bus.imem_rsp_valid);
            drop_count <= outstanding - OW'(bus.imem_rsp_valid);
        end else begin
            fetch_pc <= fire ? fetch_pc + PC_STEP : fetch_pc;
            outstanding <= outstanding + OW'(fire) - OW'(bus.imem_rsp_valid);
            drop_count <= drop_count - OW'(bus.imem_rsp_valid && drop_count != '0);
        end
    end
    fetch_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) u_queue (
        .clk(clk), .rst(rst), .flush(redir), .push(rsp_take), .pop(pop),
        .din({bus.imem_rsp_data, rsp_pc}), .dout(head), .count(bus.queue_count)
    );
    fetch_fifo #(.W(XLEN), .D(MAX_OUTSTANDING)) u_tags (
        .clk(clk), .rst(rst), .flush(redir), .push(tag_push), .pop(tag_pop),
        .din(fetch_pc), .dout(tag_pc), .count(tag_count)
    );
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle core's decode/register-read logic. It owns the fetch PC and issues word requests to a latency-tolerant instruction memory, with up to `MAX_OUTSTANDING` requests in flight. Returned instructions are buffered in a `DEPTH`-entry in-order queue and presented to the core with a valid/ready handshake. A redirect input, used for branches and jumps, flushes the queue, discards in-flight responses and restarts fetch at the new PC.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum requests accepted by memory but not yet answered; 1..DEPTH.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response valid; responses arrive in order; no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: flush and restart request.
- `redirect_pc` in 32: restart PC; bits [1:0] are forced to 0.
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: core consumes the head.
- `instr_data` out 32: head instruction; 32'h0000_0013 (NOP) when `instr_valid`=0.
- `instr_pc` out 32: PC of the head instruction; 0 when invalid.
- `queue_count` out $clog2(DEPTH+1): occupied entries.

## Operation
- **Credit rule:** `imem_req_valid` = !redirect_valid && (queue_count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - Every accepted response therefore has a reserved slot, so the queue never overflows and rsp needs no ready.
- **Request handshake:**
  - A request is accepted when `imem_req_valid && imem_req_ready`.
  - On acceptance: fetch_pc += 4 (wraps mod 2^32) and outstanding += 1.
  - `imem_req_addr` = fetch_pc and holds stable while valid and not ready.
- **Response:** a non-dropped `imem_rsp_valid` pushes {data, pc} into the queue and decrements outstanding.
  - The response PC comes from a per-entry PC tag FIFO captured at request time, depth MAX_OUTSTANDING.
- **Consumption:** `instr_valid && instr_ready` pops the head.
  - Push and pop in the same cycle leave `queue_count` unchanged.
- **Redirect** (takes priority over every other event that cycle):
  - The queue and PC-tag FIFO are cleared.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - drop_count <= outstanding minus any response arriving that cycle; outstanding <= drop_count's new value.
  - A response in the redirect cycle is discarded.
  - A pop in the redirect cycle is ignored; the core treats the redirect as killing the head.
  - No request is issued in the redirect cycle.
- **Drop mode:**
  - While drop_count > 0, each rsp decrements drop_count and outstanding and is not pushed.
  - New requests are allowed as soon as credits permit; their responses arrive after all dropped ones (in-order memory).
- **Back-to-back redirects:** the second redirect recomputes drop_count from the current outstanding; no response is ever double-counted.
- **Reset:**
  - fetch_pc=RESET_PC, queue empty, outstanding=0, drop_count=0.
  - All outputs at reset: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `instr_valid`=0, `instr_data`=NOP, `instr_pc`=0, `queue_count`=0.
  - Reset mid-operation abandons in-flight requests. The memory is reset by the same `rst`, so no stale response follows.

## Timing
- Request issue: the first request is valid in the first cycle after `rst` deasserts.
- Request to queue: rsp at edge N makes `instr_valid`=1 after edge N; there is no rsp to output bypass.
- With 1-cycle memory, `imem_req_ready`=1 and `instr_ready`=1, steady-state throughput is 1 instruction/cycle once MAX_OUTSTANDING≥2.
- Redirect at edge N:
  - `instr_valid`=0 from N.
  - New request at `redirect_pc` is valid in cycle N+1.
  - First new instruction is visible at N+1+mem_latency+1.
- All outputs are registered or decoded from registered state only. There is no combinational path from `instr_ready` or `imem_rsp_valid` to `imem_req_valid`, except via `redirect_valid` gating.

## Structure
- Package `riscv_fetch_pkg`: XLEN=32, INSTR_NOP=32'h0000_0013, PC_STEP=4, and the default RESET_PC.
- Sub-module `fetch_fifo`: a parameterized synchronous FIFO with width and depth parameters, push, pop, flush and count. It is instantiated twice:
  - {instr,pc} queue of DEPTH entries.
  - PC-tag FIFO of MAX_OUTSTANDING entries.
- Credit, drop and PC logic lives in `fetch_queue`; estimated 200–300 lines total.

## Test plan
- **Reset/first fetch:** release `rst`, memory latency 1, `instr_ready`=1 → requests at 0x0, 0x4, 0x8…; `instr_valid` first rises 2 cycles after reset release with `instr_pc`=0x0.
- **Backpressure full:** `instr_ready`=0, zero-latency memory → exactly 4 requests issued, `queue_count`=4, `imem_req_valid`=0. One pop → exactly one new request.
- **Redirect with in-flight:** latency 3, 2 outstanding, redirect to 0x0000_0102 → next `imem_req_addr`=0x100; both stale responses dropped; first `instr_pc` after the redirect is 0x100.
- **Redirect coincident with rsp and pop:** all three in one cycle → rsp not queued, `queue_count`=0 next cycle, drop_count = outstanding−1.
- **PC wrap:** redirect to 0xFFFF_FFFC → instructions at 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-fetch:** assert `rst` with queue=3 and outstanding=2 → next cycle all outputs at reset values, first request at RESET_PC.
